// File: rtl/lane_pkg.sv
// Shared defaults and helpers for the lane array FIFO.
package lane_pkg;

    localparam int LANES_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef logic [WIDTH_DEF-1:0] lane_word_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lane_fifo_mem.sv
// DEPTH x LANES x WIDTH storage; one synchronous write port, one async read port, no reset.
module lane_fifo_mem
    import lane_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata [LANES],
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata [LANES]
);

    logic [WIDTH-1:0] mem_q [DEPTH][LANES];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                mem_q[waddr][l] <= wdata[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rdata[l] = mem_q[raddr][l];
        end
    end

endmodule

// File: rtl/lane_array_fifo.sv
// Registered valid/ready FIFO of LANES-wide beats; pointers carry a wrap bit for full/empty.
// Optional LANE_FIFO_BYPASS_EN adds a zero-latency path from in_* to out_* when empty.
module lane_array_fifo
    import lane_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data [LANES],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data [LANES],
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full;
    logic             wr_en, rd_en;
    logic [WIDTH-1:0] mem_rdata [LANES];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign in_ready = !full;
    assign rd_en    = !empty && out_ready;

`ifdef LANE_FIFO_BYPASS_EN
    logic bypass;

    assign bypass    = empty && in_valid;
    assign out_valid = !empty || in_valid;
    // A bypassed beat that the consumer takes immediately never enters storage.
    assign wr_en     = in_valid && !full && !(bypass && out_ready);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            out_data[l] = bypass ? in_data[l] : mem_rdata[l];
        end
    end
`else
    assign out_valid = !empty;
    assign wr_en     = in_valid && !full;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            out_data[l] = mem_rdata[l];
        end
    end
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_en && !rd_en)      count_d = count_q + CW'(1);
            else if (!wr_en && rd_en) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

    lane_fifo_mem #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en && !clear),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_lane_array_fifo.sv
// Self-checking bench for lane_array_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_lane_array_fifo;
    import lane_pkg::*;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef LANE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid;
    lane_word_t in_data  [LANES];
    lane_word_t out_data [LANES];
    logic [2:0] count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    lane_array_fifo #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    function automatic logic [31:0] pack_out();
        logic [31:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = out_data[l];
        return r;
    endfunction

    function automatic logic [31:0] pack_in();
        logic [31:0] r;
        for (int l = 0; l < LANES; l++) r[l*8 +: 8] = in_data[l];
        return r;
    endfunction

    task automatic set_in(input logic [31:0] b);
        for (int l = 0; l < LANES; l++) in_data[l] = b[l*8 +: 8];
    endtask

    // Advance one clock edge and apply the FIFO rules to the reference queue.
    task automatic cycle();
        bit          emp, ful, push, pop, thru;
        logic [31:0] b;
        emp  = (q.size() == 0);
        ful  = (q.size() == DEPTH);
        push = in_valid && !ful;
        pop  = !emp && out_ready;
        thru = BYP && emp && in_valid && out_ready;
        b    = pack_in();
        @(posedge clk);
        if (clear) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push && !thru) q.push_back(b);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        #4 rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        idle_inputs();
        in_valid = 1'b1; set_in(32'h04030201);
        #1;
        n_tests++; if (out_valid !== BYP) begin n_fail++; $display("FAIL single_latency out_valid got %b want %b", out_valid, BYP); end
        cycle();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        n_tests++; if (pack_out() !== 32'h04030201) begin n_fail++; $display("FAIL single_data got %h want 04030201", pack_out()); end
        drain();
    endtask

    task automatic test_fill();
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_in({8'($urandom), 8'($urandom), 8'($urandom), 8'(8'h10 + i)});
            #1 cycle();
        end
        set_in(32'hEEEEEE55);
        #1;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        cycle();
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_held_count got %0d want 4", count); end
        // Full with a same-cycle pop: the pending beat must still wait.
        out_ready = 1'b1;
        #1 cycle();
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count got %0d want 3", count); end
        in_valid = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            #1;
            n_tests++; if (out_data[0] !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL fill_order[%0d] got %h want %h", i, out_data[0], 8'(8'h10 + i)); end
            cycle();
        end
        #1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_drain_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drain_valid got %b want 0", out_valid); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin set_in(32'hA0B0C000 | 32'(i)); #1 cycle(); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(32'hA0B0C000 | 32'(i + 2));
            #1;
            n_tests++; if (pack_out() !== (32'hA0B0C000 | 32'(i))) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, pack_out(), 32'hA0B0C000 | 32'(i)); end
            cycle();
            n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
        end
        in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            #1;
            n_tests++; if (pack_out() !== (32'hA0B0C000 | 32'(i))) begin n_fail++; $display("FAIL b2b_tail[%0d] got %h want %h", i, pack_out(), 32'hA0B0C000 | 32'(i)); end
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin set_in(32'(i + 7)); #1 cycle(); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        #2 rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
        q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin set_in(32'h11110000 | 32'(i)); #1 cycle(); end
        clear = 1'b1; out_ready = 1'b1; set_in(32'h99999999);
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_in_ready got %b want 1", in_ready); end
        cycle();
        idle_inputs();
        #1;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL clear_count got %0d want 0", count); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_out_valid got %b want 0", out_valid); end
        cycle();
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL clear_dropped got count %0d want 0", count); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        in_valid = 1'b1; out_ready = 1'b1; set_in(32'hDDCCBBAA);
        #1;
        if (BYP) begin
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL byp_out_valid got %b want 1", out_valid); end
            n_tests++; if (pack_out() !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL byp_data got %h want ddccbbaa", pack_out()); end
            cycle();
            in_valid = 1'b0;
            #1;
            n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count got %0d want 0", count); end
        end else begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nobyp_same_cycle got %b want 0", out_valid); end
            cycle();
            in_valid = 1'b0;
            #1;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nobyp_out_valid got %b want 1", out_valid); end
            n_tests++; if (pack_out() !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL nobyp_data got %h want ddccbbaa", pack_out()); end
            cycle();
        end
        idle_inputs();
        drain();
    endtask

    task automatic test_random();
        bit          exp_valid, exp_ready;
        logic [31:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            set_in($urandom());
            #1;
            exp_valid = (q.size() > 0) || (BYP && in_valid);
            exp_ready = (q.size() < DEPTH);
            exp_data  = (q.size() > 0) ? q[0] : pack_in();
            n_tests++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_out_valid[%0d] got %b want %b", i, out_valid, exp_valid); end
            n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got %b want %b", i, in_ready, exp_ready); end
            n_tests++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, q.size()); end
            if (exp_valid) begin
                n_tests++; if (pack_out() !== exp_data) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, pack_out(), exp_data); end
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        set_in(32'h0);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_async_reset();
        test_clear();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
